// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types, sizes and lane-merge helper for dmem_arbiter
// Contents:
//   WORDS, AW     memory depth in words and word-address width
//   dmem_state_t  IDLE / MERGE
//   dmem_req_t    one requester's fields (we, addr, be, wdata)
//   be_merge      per-lane select between new and old word
package dmem_pkg;

  localparam int WORDS = 1024;
  localparam int AW    = $clog2(WORDS);

  typedef enum logic {IDLE, MERGE} dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_req_t;

  // Lane i takes new_word when be[i] is set, otherwise keeps old_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two-port request/response bundle for dmem_arbiter
// Signals (index = port, 0 = load/store unit, 1 = loader):
//   req_valid/req_ready  request handshake, transfer on valid & ready
//   req_we/addr/be/wdata request fields, held stable until ready
//   resp_valid           per-port one-cycle completion pulse
//   resp_rdata/resp_err  shared completion data and out-of-range flag
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][3:0]  req_be;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational two-way round-robin arbiter
// Ports:
//   req   in  [1:0]  requests
//   last  in  1      index of the most recent winner
//   grant out [1:0]  one-hot (or zero) grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // A lone requester always wins; on contention the port that did not win last time goes.
  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data RAM between two requesters
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         dmem_arbiter_if.slave request/response bundle for ports 0 and 1
//   mem_we      RAM write enable
//   mem_addr    RAM word address
//   mem_wdata   RAM write data
//   mem_rdata   RAM combinational read data
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  dmem_arbiter_if.slave       bus,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  dmem_state_t   state;
  logic          rr_last;
  logic [AW-1:0] m_word;
  logic [31:0]   m_data;
  logic          m_port;

  logic [1:0]    grant;
  logic          acc;
  logic          sel;
  dmem_req_t     sel_req;
  logic [AW-1:0] word;
  logic          oor;
  logic          partial;
  logic          unused_addr_lsb;

  // Gating with rst_n keeps ready (and hence every memory strobe) low while reset is held.
  rr_arb2 u_arb (
    .req   (bus.req_valid & {2{rst_n && state == IDLE}}),
    .last  (rr_last),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign acc           = |grant;
  assign sel           = grant[1];

  always_comb begin
    sel_req.we    = bus.req_we[sel];
    sel_req.addr  = bus.req_addr[sel];
    sel_req.be    = bus.req_be[sel];
    sel_req.wdata = bus.req_wdata[sel];
  end

  // Byte offset is meaningless here: lanes are chosen by be.
  assign word            = sel_req.addr[AW+1:2];
  assign unused_addr_lsb = ^sel_req.addr[1:0];
  assign oor             = |sel_req.addr[31:AW+2];
  assign partial         = (sel_req.be != 4'hF) && (sel_req.be != 4'h0);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n && state == MERGE) begin
      mem_we    = 1'b1;
      mem_addr  = m_word;
      mem_wdata = m_data;
    end else if (acc) begin
      mem_addr = word;
      if (sel_req.we && !oor && sel_req.be == 4'hF) begin
        mem_we    = 1'b1;
        mem_wdata = sel_req.wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_last        <= 1'b1;
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      m_word         <= '0;
      m_data         <= '0;
      m_port         <= 1'b0;
    end else begin
      bus.resp_valid <= '0;
      bus.resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            rr_last <= sel;
            if (sel_req.we && !oor && partial) begin
              // Read half of the read-modify-write: merge now, write in MERGE.
              state  <= MERGE;
              m_word <= word;
              m_data <= be_merge(mem_rdata, sel_req.wdata, sel_req.be);
              m_port <= sel;
            end else begin
              bus.resp_valid <= grant;
              bus.resp_err   <= oor;
              bus.resp_rdata <= (!oor && !sel_req.we) ? mem_rdata : 32'h0;
            end
          end
        end
        MERGE: begin
          state                  <= IDLE;
          bus.resp_valid[m_port] <= 1'b1;
          bus.resp_rdata         <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 1024x32 data memory (RAM: clk, we, addr, dataIn, dataOut; combinational read, write on rising clk) between two requesters.
- Port 0 is the core load/store unit. Port 1 is the program/debug loader.
- Adds per-byte write enables through a read-modify-write sequence, a round-robin grant, and range checking.
- Sits between the requesters and RAM in the single-cycle top level.

Parameters:
- WORDS, 1024, memory depth in 32-bit words.
- AW, $clog2(WORDS) = 10, memory word-address width.
- DW, 32, data width; fixed at 32, byte enables assume 4 lanes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [1:0]  request present, per port.
- req_ready  out  [1:0]  request accepted this cycle, per port; at most one bit set.
- req_we  in  [1:0]  1 = store, 0 = load.
- req_addr  in  [1:0][31:0]  byte address.
- req_be  in  [1:0][3:0]  byte enables, stores only.
- req_wdata  in  [1:0][31:0]  store data, lane-aligned.
- resp_valid  out  [1:0]  one-cycle completion pulse, per port.
- resp_rdata  out  32  registered load data; also valid for store completions (0).
- resp_err  out  1  completion is an out-of-range access; qualified by resp_valid.
- mem_we  out  1  to RAM we.
- mem_addr  out  AW  to RAM addr.
- mem_wdata  out  32  to RAM dataIn.
- mem_rdata  in  32  from RAM dataOut.

Behaviour:
- Reset: the following are forced asynchronously while rst_n=0.
  - State=IDLE.
  - rr_last=1, so port 0 wins first.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-MERGE drops the pending store: no memory write and no response.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - req_ready is combinational, asserted only in IDLE, and only to the grant winner.
  - A requester must hold its fields stable until it sees ready.
- Arbitration:
  - With one valid port, that port wins.
  - With both valid, the winner is the port not equal to rr_last.
  - rr_last updates on every accepted transfer.
- Decode:
  - word = req_addr[AW+1:2]. Address bits [1:0] are ignored because lanes come from be.
  - out_of_range = |req_addr[31:AW+2].
- IDLE, accepted load:
  - mem_addr=word, mem_we=0.
  - resp_rdata <= mem_rdata at the edge.
  - resp_valid[i]=1 next cycle, so latency is 1.
  - Throughput is 1 per cycle.
- IDLE, accepted store with be=4'hF:
  - mem_we=1, mem_wdata=req_wdata, same cycle.
  - Response pulse next cycle, resp_rdata=0.
- IDLE, accepted store with be=4'h0:
  - No mem_we.
  - Response pulse next cycle.
- IDLE, accepted store with a partial be:
  - mem_addr=word, mem_we=0.
  - Latch merged = per lane be ? wdata : mem_rdata, plus word and port id.
  - Go to MERGE.
- MERGE:
  - mem_we=1, mem_addr=latched word, mem_wdata=merged.
  - req_ready=0 on both ports.
  - Return to IDLE.
  - resp_valid pulses the cycle after MERGE, so latency is 2 and no acceptance occurs in MERGE.
- Out of range, any op:
  - Accepted normally, no mem_we.
  - Response next cycle with resp_err=1, resp_rdata=0.
- Outside these cases mem_we=0. resp_valid is one-hot or zero.
- States: IDLE, MERGE. Transitions:
  - IDLE to MERGE on an accepted in-range partial store.
  - MERGE to IDLE unconditionally.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic {IDLE, MERGE} dmem_state_t.
  - typedef struct: we, addr, be, wdata, forming dmem_req_t.
  - localparams WORDS and AW.
  - Function be_merge(old, new, be).
- One sub-module rr_arb2 (req[1:0], last, grant[1:0]), purely combinational. It is reusable for other shared resources.

Test Plan:
- Reset asserted during MERGE (rst_n low between edges) -> all outputs 0 immediately. No write occurs, and a subsequent read of that word returns the old value.
- Port 0 store 0x0000_0010, be=F, data DEADBEEF -> same cycle mem_we=1, mem_addr=4. resp_valid=01 next cycle. A following load of 0x10 returns DEADBEEF with latency 1.
- Port 0 byte store 0x0000_0011, be=0010, data 0000AA00 over DEADBEEF -> mem_we=0 in cycle 1, then mem_we=1 with mem_wdata DEADAAEF in cycle 2. req_ready=00 in cycle 2, and resp_valid the cycle after.
- Both ports hold valid loads continuously after reset -> grants go 0,1,0,1 on consecutive cycles. resp_valid mirrors them one cycle later.
- Port 1 load at 0x0000_1000 -> accepted, no mem_we, resp_err=1 and resp_rdata=0 next cycle.
- Port 1 alone issues 4 back-to-back loads of words 0..3 -> 4 accepts in 4 cycles. Data arrives in order, one cycle later each.
